cpu_run_ctrl: RTL and testbench



---
 rtl/cpu_run_ctrl_pkg.sv | 16 +
 rtl/btn_pulse.sv | 35 +++
 rtl/cpu_run_ctrl.sv | 158 +++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg
//   Shared definitions for the CPU run-mode controller.
//   - run_mode_e : run-state encoding, also exported on the `mode` port
//   - BRK_RST    : breakpoint address after reset (never matches a real
//                  word-aligned PC, so a disarmed breakpoint cannot fire)
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        CPU_PAUSE = 2'b00,
        CPU_STEP  = 2'b01,
        CPU_CONT  = 2'b10
    } run_mode_e;

    localparam logic [31:0] BRK_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/btn_pulse.sv
// btn_pulse
//   Synchronizes a raw level button into the clk domain and emits a single
//   registered 1-cycle pulse per rising edge. A button held high produces
//   only one pulse.
//   Latency: raw rising before edge k -> pulse high in cycle k+SYNC_STAGES.
// Ports:
//   clk   - system clock
//   rstn  - asynchronous active-low reset
//   btn   - raw button level (asynchronous to clk)
//   pulse - one-cycle pulse per press
module btn_pulse #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            last_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
            last_q <= sync_q[SYNC_STAGES-1];
            pulse  <= sync_q[SYNC_STAGES-1] & ~last_q;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run-mode controller for the single-cycle CPU. Turns the step/cont
//   buttons into a single cpu_en qualifier, supports multi-step runs and a
//   hardware breakpoint, and reports run state for display.
// Ports:
//   clk, rstn   - clock, asynchronous active-low reset
//   step, cont  - raw button levels
//   step_n      - steps per step press (0 is treated as 1)
//   brk_set     - load brk_addr into the breakpoint (PAUSE only)
//   brk_clr     - disarm the breakpoint (any state, beats brk_set)
//   brk_addr    - breakpoint address to load
//   pc          - current CPU PC (registered CPU output)
//   cpu_en      - CPU executes one instruction at the next edge
//   pause, mode - run state
//   brk_hit     - last stop was caused by the breakpoint (sticky)
//   brk_vld     - breakpoint armed
//   steps_left  - remaining steps while in STEP
//   cyc_cnt     - number of cycles with cpu_en high (wraps)
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             step,
    input  logic             cont,
    input  logic [CNT_W-1:0] step_n,
    input  logic             brk_set,
    input  logic             brk_clr,
    input  logic [31:0]      brk_addr,
    input  logic [31:0]      pc,
    output logic             cpu_en,
    output logic             pause,
    output logic [1:0]       mode,
    output logic             brk_hit,
    output logic             brk_vld,
    output logic [CNT_W-1:0] steps_left,
    output logic [31:0]      cyc_cnt
);

    logic             step_p;
    logic             cont_p;
    run_mode_e        state_q;
    logic [31:0]      brk_q;
    logic             skip_q;
    logic             hit;
    logic [CNT_W-1:0] steps_load;

    btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_step_pulse (
        .clk   (clk),
        .rstn  (rstn),
        .btn   (step),
        .pulse (step_p)
    );

    btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_cont_pulse (
        .clk   (clk),
        .rstn  (rstn),
        .btn   (cont),
        .pulse (cont_p)
    );

    // skip masks the match on the first enabled cycle after leaving PAUSE,
    // so a run can resume from the address it stopped on.
    assign hit        = brk_vld & (pc == brk_q) & ~skip_q;
    assign steps_load = (step_n == '0) ? CNT_W'(1) : step_n;

    // Combinational so a breakpoint match blocks the instruction at brk_q
    // in the same cycle, and so reset drops it without waiting for a clock.
    always_comb begin
        cpu_en = 1'b0;
        case (state_q)
            CPU_STEP: cpu_en = ~hit;
            CPU_CONT: cpu_en = ~hit & ~step_p;
            default:  cpu_en = 1'b0;
        endcase
    end

    assign mode  = state_q;
    assign pause = (state_q == CPU_PAUSE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= CPU_PAUSE;
            steps_left <= '0;
            brk_hit    <= 1'b0;
            skip_q     <= 1'b0;
        end else begin
            if (cpu_en) skip_q <= 1'b0;
            case (state_q)
                CPU_PAUSE: begin
                    // step wins over a simultaneous cont
                    if (step_p) begin
                        state_q    <= CPU_STEP;
                        steps_left <= steps_load;
                        skip_q     <= 1'b1;
                        brk_hit    <= 1'b0;
                    end else if (cont_p) begin
                        state_q <= CPU_CONT;
                        skip_q  <= 1'b1;
                        brk_hit <= 1'b0;
                    end
                end
                CPU_STEP: begin
                    if (hit) begin
                        state_q <= CPU_PAUSE;
                        brk_hit <= 1'b1;
                    end else if (cont_p) begin
                        state_q    <= CPU_CONT;
                        steps_left <= '0;
                    end else if (steps_left <= CNT_W'(1)) begin
                        state_q    <= CPU_PAUSE;
                        steps_left <= '0;
                    end else begin
                        steps_left <= steps_left - CNT_W'(1);
                    end
                end
                CPU_CONT: begin
                    if (hit) begin
                        state_q <= CPU_PAUSE;
                        brk_hit <= 1'b1;
                    end else if (step_p) begin
                        state_q <= CPU_PAUSE;
                    end
                end
                default: begin
                    // unreachable encoding 2'b11
                    state_q    <= CPU_PAUSE;
                    steps_left <= '0;
                end
            endcase
        end
    end

    // Breakpoint register; a clear in the same cycle as a set wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            brk_q   <= BRK_RST;
            brk_vld <= 1'b0;
        end else if (brk_clr) begin
            brk_vld <= 1'b0;
        end else if (brk_set && (state_q == CPU_PAUSE)) begin
            brk_q   <= brk_addr;
            brk_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'(cpu_en);
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;
    import cpu_run_ctrl_pkg::*;

    localparam int CNT_W = 8;

    logic             clk      = 1'b0;
    logic             rstn     = 1'b0;
    logic             step     = 1'b0;
    logic             cont     = 1'b0;
    logic [CNT_W-1:0] step_n   = '0;
    logic             brk_set  = 1'b0;
    logic             brk_clr  = 1'b0;
    logic [31:0]      brk_addr = '0;
    logic [31:0]      pc       = '0;
    logic             cpu_en;
    logic             pause;
    logic [1:0]       mode;
    logic             brk_hit;
    logic             brk_vld;
    logic [CNT_W-1:0] steps_left;
    logic [31:0]      cyc_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   en_cnt  = 0;
    logic en_cur  = 1'b0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .step       (step),
        .cont       (cont),
        .step_n     (step_n),
        .brk_set    (brk_set),
        .brk_clr    (brk_clr),
        .brk_addr   (brk_addr),
        .pc         (pc),
        .cpu_en     (cpu_en),
        .pause      (pause),
        .mode       (mode),
        .brk_hit    (brk_hit),
        .brk_vld    (brk_vld),
        .steps_left (steps_left),
        .cyc_cnt    (cyc_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock: the bench acts as the CPU, advancing pc by 4 after every
    // enabled cycle, then samples cpu_en for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (en_cur) pc = pc + 32'd4;
        #1;
        en_cur = cpu_en;
        if (cpu_en) en_cnt++;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_en"},    32'(cpu_en),     32'd0);
        check_eq({tag, "_pause"}, 32'(pause),      32'd1);
        check_eq({tag, "_mode"},  32'(mode),       32'(CPU_PAUSE));
        check_eq({tag, "_hit"},   32'(brk_hit),    32'd0);
        check_eq({tag, "_vld"},   32'(brk_vld),    32'd0);
        check_eq({tag, "_steps"}, 32'(steps_left), 32'd0);
        check_eq({tag, "_cyc"},   cyc_cnt,         32'd0);
        check_eq({tag, "_brkq"},  dut.brk_q,       32'hFFFF_FFFF);
    endtask

    initial begin
        // reset
        repeat (3) tick();
        check_reset_vals("rst");
        rstn = 1'b1;
        repeat (2) tick();
        check_eq("rst_rel_pause", 32'(pause), 32'd1);

        // single step with step_n = 0, including button latency
        step_n = '0;
        en_cnt = 0;
        step   = 1'b1;
        repeat (3) tick();
        check_eq("lat_pulse_cyc_en", 32'(cpu_en), 32'd0);
        tick();
        check_eq("lat_first_en", 32'(cpu_en), 32'd1);
        step = 1'b0;
        repeat (8) tick();
        check_eq("s0_en_cnt", 32'(en_cnt), 32'd1);
        check_eq("s0_cyc", cyc_cnt, 32'd1);
        check_eq("s0_pause", 32'(pause), 32'd1);
        check_eq("s0_steps", 32'(steps_left), 32'd0);

        // step of 5
        step_n = 8'd5;
        step   = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) step = 1'b0;
            check_eq($sformatf("s5_steps%0d", i), 32'(steps_left), 32'(5 - i));
            check_eq($sformatf("s5_en%0d", i), 32'(cpu_en), (i < 5) ? 32'd1 : 32'd0);
        end
        check_eq("s5_cyc", cyc_cnt, 32'd6);
        check_eq("s5_pause", 32'(pause), 32'd1);

        // breakpoint at 0x10, run from pc = 0
        pc       = 32'd0;
        brk_addr = 32'h0000_0010;
        brk_set  = 1'b1;
        tick();
        brk_set = 1'b0;
        check_eq("bp_vld", 32'(brk_vld), 32'd1);
        check_eq("bp_q", dut.brk_q, 32'h0000_0010);
        cont = 1'b1;
        repeat (3) tick();
        cont = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("bp_run_en%0d", i), 32'(cpu_en), 32'd1);
        end
        tick();
        check_eq("bp_stop_en", 32'(cpu_en), 32'd0);
        tick();
        check_eq("bp_stop_pause", 32'(pause), 32'd1);
        check_eq("bp_stop_hit", 32'(brk_hit), 32'd1);
        check_eq("bp_stop_pc", pc, 32'h0000_0010);
        check_eq("bp_cyc", cyc_cnt, 32'd10);

        // resume from the breakpoint address
        cont = 1'b1;
        repeat (3) tick();
        cont = 1'b0;
        tick();
        check_eq("skip_en", 32'(cpu_en), 32'd1);
        check_eq("skip_hit_clr", 32'(brk_hit), 32'd0);
        check_eq("skip_mode", 32'(mode), 32'(CPU_CONT));
        tick();
        check_eq("skip_run_en", 32'(cpu_en), 32'd1);

        // step acts as halt in CONT
        step = 1'b1;
        repeat (2) tick();
        check_eq("halt_pre_en", 32'(cpu_en), 32'd1);
        tick();
        check_eq("halt_en", 32'(cpu_en), 32'd0);
        tick();
        check_eq("halt_pause", 32'(pause), 32'd1);
        check_eq("halt_hit", 32'(brk_hit), 32'd0);
        step = 1'b0;
        repeat (3) tick();

        // set then set+clr together
        brk_addr = 32'h0000_0040;
        brk_set  = 1'b1;
        tick();
        brk_set = 1'b0;
        check_eq("setclr_pre_vld", 32'(brk_vld), 32'd1);
        brk_set = 1'b1;
        brk_clr = 1'b1;
        tick();
        brk_set = 1'b0;
        brk_clr = 1'b0;
        check_eq("setclr_vld", 32'(brk_vld), 32'd0);

        // held button gives one step
        step_n = 8'd1;
        en_cnt = 0;
        step   = 1'b1;
        repeat (100) tick();
        step = 1'b0;
        repeat (4) tick();
        check_eq("hold_en_cnt", 32'(en_cnt), 32'd1);
        check_eq("hold_pause", 32'(pause), 32'd1);

        // arm a far breakpoint, run, then reset mid-CONT
        brk_addr = 32'h1000_0000;
        brk_set  = 1'b1;
        tick();
        brk_set = 1'b0;
        cont    = 1'b1;
        repeat (3) tick();
        cont = 1'b0;
        tick();
        check_eq("cont_run_en", 32'(cpu_en), 32'd1);
        brk_addr = 32'h2000_0000;
        brk_set  = 1'b1;
        tick();
        brk_set = 1'b0;
        check_eq("brk_set_ignored", dut.brk_q, 32'h1000_0000);
        check_eq("cont_run_en2", 32'(cpu_en), 32'd1);
        rstn = 1'b0;
        #1;
        check_reset_vals("async_rst");
        repeat (2) tick();
        rstn = 1'b1;
        tick();

        // cycle counter wrap
        force dut.cyc_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cyc_cnt;
        #1;
        check_eq("wrap_pre", cyc_cnt, 32'hFFFF_FFFF);
        step_n = 8'd1;
        step   = 1'b1;
        repeat (3) tick();
        step = 1'b0;
        repeat (4) tick();
        check_eq("wrap_cyc", cyc_cnt, 32'd0);
        check_eq("wrap_pause", 32'(pause), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
